// File: rtl/path_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : path_accum_pkg
//  Description : Shared constants and FSM state encoding for the path
//                accumulator and its plot buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package path_accum_pkg;

    localparam int DEPTH     = 16;
    localparam int W         = 8;
    localparam int ENE_ACC_W = 16;
    localparam int LEN_W     = 5;
    localparam logic [ENE_ACC_W-1:0] ENE_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/path_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : path_fifo
//  Description : DEPTH x W register FIFO holding the plot codes of one path.
//                Pointers wrap modulo DEPTH; count is the number of entries
//                not yet popped. Contents are not cleared by reset or clr.
//  Revision    : 1.0 - initial release
// ============================================================================
module path_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         wr_en_i,
    input  logic [W-1:0]                 wr_data_i,
    input  logic                         rd_en_i,
    output logic [W-1:0]                 rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for pointers and occupancy; clr restarts an empty buffer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_d + 1'b1;
            end
            if (rd_en_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = count_d - 1'b1;
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/path_accum.sv
`default_nettype none
// ============================================================================
//  Module      : path_accum
//  Description : Accumulates the selected minimum energy of each path step
//                (saturating) and buffers the plot codes, then drains them
//                oldest-first to a consumer and pulses done when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module path_accum #(
    parameter int DEPTH = path_accum_pkg::DEPTH,
    parameter int W     = path_accum_pkg::W
) (
    input  logic          m_clock,
    input  logic          p_reset,
    input  logic          start,
    input  logic          step_exe,
    input  logic [W-1:0]  inene,
    input  logic [W-1:0]  inplot,
    input  logic          finish,
    input  logic          rd_req,
    output logic [15:0]   total_ene,
    output logic [4:0]    path_len,
    output logic [W-1:0]  plot_out,
    output logic          plot_valid,
    output logic          busy,
    output logic          overflow,
    output logic          done
);

    import path_accum_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    state_t                  state_q, state_d;
    logic [ENE_ACC_W-1:0]    total_q, total_d;
    logic [LEN_W-1:0]        len_q,   len_d;
    logic                    ovf_q,   ovf_d;
    logic                    done_q,  done_d;

    logic                    fifo_clr;
    logic                    fifo_wr;
    logic                    fifo_rd;
    logic [W-1:0]            fifo_data;
    logic [CW-1:0]           remaining;
    logic [ENE_ACC_W:0]      ene_sum;

    // Energy sum with one carry bit so saturation is a single bit test.
    assign ene_sum = {1'b0, total_q} + (ENE_ACC_W + 1)'(inene);

    // Control FSM and accumulator next-state; start overrides everything.
    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        fifo_clr = 1'b0;
        fifo_wr  = 1'b0;
        fifo_rd  = 1'b0;
        if (start) begin
            state_d  = ACCUM;
            total_d  = '0;
            len_d    = '0;
            ovf_d    = 1'b0;
            fifo_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                ACCUM: begin
                    // A step coincident with finish is taken before draining.
                    if (step_exe) begin
                        total_d = ene_sum[ENE_ACC_W] ? ENE_SAT : ene_sum[ENE_ACC_W-1:0];
                        if (len_q < LEN_W'(DEPTH)) begin
                            fifo_wr = 1'b1;
                            len_d   = len_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (finish) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (remaining == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (rd_req) begin
                        fifo_rd = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and accumulator registers.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q <= IDLE;
            total_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    path_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk_i     (m_clock),
        .rst_i     (p_reset),
        .clr_i     (fifo_clr),
        .wr_en_i   (fifo_wr),
        .wr_data_i (inplot),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_data),
        .count_o   (remaining)
    );

    assign plot_valid = (state_q == DRAIN) && (remaining != '0);
    assign plot_out   = plot_valid ? fifo_data : '0;
    assign busy       = (state_q != IDLE);
    assign total_ene  = total_q;
    assign path_len   = len_q;
    assign overflow   = ovf_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_path_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_path_accum
//  Description : Self-checking bench for path_accum: directed path scenarios
//                followed by randomized traffic, compared every cycle against
//                a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_path_accum;

    localparam int DEPTH = 16;
    localparam int W     = 8;

    logic          m_clock = 1'b0;
    logic          p_reset, start, step_exe, finish, rd_req;
    logic [W-1:0]  inene, inplot;
    logic [15:0]   total_ene;
    logic [4:0]    path_len;
    logic [W-1:0]  plot_out;
    logic          plot_valid, busy, overflow, done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 = idle, 1 = accumulating, 2 = draining.
    int            m_mode = 0;
    int            m_tot  = 0;
    int            m_len  = 0;
    bit            m_ovf  = 1'b0;
    bit            m_done = 1'b0;
    logic [W-1:0]  m_q[$];

    path_accum #(.DEPTH(DEPTH), .W(W)) dut (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .start      (start),
        .step_exe   (step_exe),
        .inene      (inene),
        .inplot     (inplot),
        .finish     (finish),
        .rd_req     (rd_req),
        .total_ene  (total_ene),
        .path_len   (path_len),
        .plot_out   (plot_out),
        .plot_valid (plot_valid),
        .busy       (busy),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 m_clock = ~m_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge worth of the behavioural rules.
    task automatic model_edge(input bit rst_v, st_v, stp_v, input logic [W-1:0] e_v, p_v,
                              input bit fin_v, rd_v);
        m_done = 1'b0;
        if (rst_v) begin
            m_mode = 0; m_tot = 0; m_len = 0; m_ovf = 1'b0; m_q.delete();
        end else if (st_v) begin
            m_mode = 1; m_tot = 0; m_len = 0; m_ovf = 1'b0; m_q.delete();
        end else if (m_mode == 1) begin
            if (stp_v) begin
                m_tot = m_tot + int'(e_v);
                if (m_tot > 65535) m_tot = 65535;
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(p_v);
                    m_len++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (fin_v) m_mode = 2;
        end else if (m_mode == 2) begin
            if (m_q.size() == 0) begin
                m_mode = 0;
                m_done = 1'b1;
            end else if (rd_v) begin
                void'(m_q.pop_front());
            end
        end
    endtask

    task automatic compare_all();
        logic          exp_valid;
        logic [W-1:0]  exp_plot;
        exp_valid = (m_mode == 2) && (m_q.size() > 0);
        exp_plot  = exp_valid ? m_q[0] : '0;
        chk("total_ene",  32'(total_ene),  32'(m_tot));
        chk("path_len",   32'(path_len),   32'(m_len));
        chk("plot_valid", 32'(plot_valid), 32'(exp_valid));
        chk("plot_out",   32'(plot_out),   32'(exp_plot));
        chk("busy",       32'(busy),       32'(m_mode != 0));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("done",       32'(done),       32'(m_done));
    endtask

    // Apply inputs for one cycle, advance past the edge, then check.
    task automatic cyc(input bit rst_v, st_v, stp_v, input logic [W-1:0] e_v, p_v,
                       input bit fin_v, rd_v);
        p_reset  = rst_v;
        start    = st_v;
        step_exe = stp_v;
        inene    = e_v;
        inplot   = p_v;
        finish   = fin_v;
        rd_req   = rd_v;
        @(posedge m_clock);
        #1;
        model_edge(rst_v, st_v, stp_v, e_v, p_v, fin_v, rd_v);
        compare_all();
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 3; i++) cyc(0, 0, 0, '0, '0, 0, 1);
    endtask

    initial begin
        p_reset = 1'b1; start = 1'b0; step_exe = 1'b0; finish = 1'b0;
        rd_req = 1'b0; inene = '0; inplot = '0;

        // Reset state.
        cyc(1, 0, 0, '0, '0, 0, 0);
        cyc(1, 0, 1, 8'h12, 8'h34, 1, 1);
        chk("reset_busy", 32'(busy), 32'd0);
        idle_cyc();

        // Steps in IDLE are ignored.
        cyc(0, 0, 1, 8'h40, 8'h11, 1, 1);
        chk("idle_ignore", 32'(total_ene), 32'd0);

        // Basic path of three steps.
        cyc(0, 1, 0, '0, '0, 0, 0);
        cyc(0, 0, 1, 8'd5, 8'h01, 0, 0);
        cyc(0, 0, 1, 8'd7, 8'h02, 0, 0);
        cyc(0, 0, 1, 8'd3, 8'h04, 0, 0);
        cyc(0, 0, 0, '0, '0, 1, 0);
        chk("basic_len", 32'(path_len), 32'd3);
        chk("basic_ene", 32'(total_ene), 32'd15);
        chk("basic_first", 32'(plot_out), 32'h01);
        cyc(0, 0, 0, '0, '0, 0, 1);
        cyc(0, 0, 0, '0, '0, 0, 1);
        chk("basic_last", 32'(plot_out), 32'h04);
        cyc(0, 0, 0, '0, '0, 0, 1);
        chk("basic_nodone_yet", 32'(done), 32'd0);
        idle_cyc();
        chk("basic_done", 32'(done), 32'd1);
        idle_cyc();
        chk("basic_hold_len", 32'(path_len), 32'd3);

        // Seventeen full-scale steps overflow the buffer.
        cyc(0, 1, 0, '0, '0, 0, 0);
        for (int i = 0; i < 17; i++) cyc(0, 0, 1, 8'hFF, 8'(i), 0, 0);
        cyc(0, 0, 0, '0, '0, 1, 0);
        chk("ovf_len", 32'(path_len), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_ene", 32'(total_ene), 32'd4335);
        drain_all();

        // Energy saturation.
        cyc(0, 1, 0, '0, '0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 0, 1, 8'hFF, 8'hAA, 0, 0);
        chk("sat_ene", 32'(total_ene), 32'hFFFF);
        chk("sat_ovf", 32'(overflow), 32'd1);
        cyc(0, 0, 0, '0, '0, 1, 0);
        drain_all();

        // Empty path: done two cycles after finish.
        cyc(0, 1, 0, '0, '0, 0, 0);
        cyc(0, 0, 0, '0, '0, 1, 0);
        chk("empty_valid", 32'(plot_valid), 32'd0);
        cyc(0, 0, 0, '0, '0, 0, 1);
        chk("empty_done", 32'(done), 32'd1);
        idle_cyc();
        chk("empty_busy", 32'(busy), 32'd0);

        // Step coincident with finish is accepted first.
        cyc(0, 1, 0, '0, '0, 0, 0);
        cyc(0, 0, 1, 8'd1, 8'h20, 0, 0);
        cyc(0, 0, 1, 8'd2, 8'h10, 0, 0);
        cyc(0, 0, 1, 8'd9, 8'h08, 1, 0);
        chk("cofin_len", 32'(path_len), 32'd3);
        cyc(0, 0, 0, '0, '0, 0, 1);
        cyc(0, 0, 0, '0, '0, 0, 1);
        chk("cofin_last", 32'(plot_out), 32'h08);
        drain_all();

        // Reset in the middle of a drain, then start with a step.
        cyc(0, 1, 0, '0, '0, 0, 0);
        cyc(0, 0, 1, 8'd4, 8'h33, 0, 0);
        cyc(0, 0, 1, 8'd4, 8'h44, 1, 0);
        cyc(0, 0, 0, '0, '0, 0, 1);
        cyc(1, 0, 0, '0, '0, 0, 1);
        chk("rst_drain_busy", 32'(busy), 32'd0);
        idle_cyc();
        chk("rst_drain_done", 32'(done), 32'd0);
        cyc(0, 1, 1, 8'd6, 8'h66, 0, 0);
        chk("start_step_len", 32'(path_len), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 5000; i++) begin
            bit st_v;
            st_v = (m_mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
            cyc($urandom_range(0, 299) == 0, st_v, 1'($urandom_range(0, 1)),
                W'($urandom), W'($urandom), $urandom_range(0, 29) == 0,
                $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/path_accum.md
PATH_ACCUM -- requirements
Module: path_accum

Interface
REQ-001 SHALL have parameter DEPTH, default 16: path buffer entries.
REQ-002 SHALL have parameter W, default 8: energy and plot width.
REQ-003 SHALL have port m_clock, input, 1: sole clock, rising edge.
REQ-004 SHALL have port p_reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: clear all state and begin a new path.
REQ-006 SHALL have port step_exe, input, 1: inene/inplot valid this cycle (min_select result).
REQ-007 SHALL have port inene, input, W: selected minimum energy.
REQ-008 SHALL have port inplot, input, W: selected ud_lr plot code.
REQ-009 SHALL have port finish, input, 1: end of path; begin drain.
REQ-010 SHALL have port rd_req, input, 1: consumer pops one plot entry.
REQ-011 SHALL have port total_ene, output, 16: accumulated energy, saturating.
REQ-012 SHALL have port path_len, output, 5: entries stored, 0..DEPTH.
REQ-013 SHALL have port plot_out, output, W: oldest undrained plot entry.
REQ-014 SHALL have port plot_valid, output, 1: plot_out valid.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.
REQ-016 SHALL have port overflow, output, 1: sticky; step arrived with buffer full.
REQ-017 SHALL have port done, output, 1: one-cycle pulse on drain completion.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, DRAIN.
REQ-019 In IDLE, start SHALL clear total_ene, path_len, pointers, overflow and enter ACCUM next edge; step_exe, finish, rd_req ignored.
REQ-020 In ACCUM, step_exe SHALL add zero-extended inene to total_ene, saturating at 0xFFFF.
REQ-021 In ACCUM, step_exe with path_len<DEPTH SHALL write inplot at write pointer and increment path_len; with path_len==DEPTH plot dropped, overflow set, energy still accumulated.
REQ-022 In ACCUM, finish SHALL enter DRAIN; step_exe in the same cycle SHALL be accepted first.
REQ-023 start in ACCUM or DRAIN SHALL clear as REQ-019 and enter ACCUM; simultaneous step_exe/finish/rd_req ignored; no done pulse.
REQ-024 Priority SHALL be p_reset > start > (finish with step_exe) > rd_req.
REQ-025 In DRAIN, plot_valid SHALL be 1 while remaining count >0; plot_out SHALL be combinational read of buffer at read pointer, order FIFO (oldest first).
REQ-026 rd_req with plot_valid SHALL advance read pointer and decrement remaining; rd_req without plot_valid ignored.
REQ-027 When remaining is 0 in DRAIN (after last pop, or on entry with path_len 0), next edge SHALL enter IDLE and set done for exactly one cycle.
REQ-028 Last-pop edge SHALL leave remaining 0; done SHALL assert one edge later, coincident with IDLE.
REQ-029 plot_out SHALL be 0 when plot_valid is 0.
REQ-030 total_ene, path_len, overflow SHALL hold after drain until next start.
REQ-031 Pointers SHALL wrap modulo DEPTH; remaining SHALL equal path_len on DRAIN entry.

Reset
REQ-032 p_reset SHALL force IDLE; total_ene=0, path_len=0, plot_valid=0, plot_out=0, busy=0, overflow=0, done=0, pointers=0.
REQ-033 p_reset mid-ACCUM or mid-DRAIN SHALL abort with no done pulse; buffer contents need not be cleared.

Structure
REQ-034 Shared package SHALL hold FSM state encoding, DEPTH, W, ENE_ACC_W=16, ENE_SAT=0xFFFF.
REQ-035 Buffer SHALL be sub-module path_fifo (DEPTH x W registers, wr/rd pointers, count); FSM and accumulator in path_accum.

Verification
REQ-036 start; steps (5,0x01),(7,0x02),(3,0x04); finish -> path_len=3, total_ene=15, drain yields 0x01,0x02,0x04, done one cycle after third pop.
REQ-037 start; 17 steps of 0xFF -> path_len=16, overflow=1, total_ene=17*255=4335; drain yields 16 entries.
REQ-038 start; 300 steps of 0xFF -> total_ene=0xFFFF (saturated), overflow=1.
REQ-039 start; finish with no steps -> plot_valid never 1, done pulses 2 cycles after finish, busy=0 thereafter.
REQ-040 finish with step_exe (9,0x08) same cycle after 2 steps -> path_len=3, last drained entry 0x08; rd_req held high drains one entry per cycle.
REQ-041 p_reset mid-DRAIN after one pop -> IDLE next edge, all outputs 0, no done; start with step_exe same cycle -> step ignored, path_len=0.
